ram_arbiter: RTL and testbench

Two-master arbiter sharing the single data RAM port between the RV32I core (master 0) and a DMA/peripheral engine (master 1). It sits between the masters' request interfaces and the RAM's `strb/we/addr/wData/rData` port. It serialises accesses with a round-robin policy, a three-state sequencer and a req/ready handshake. Each master sees registered read data and a one-cycle `ready` pulse per completed transaction.

---
 rtl/ram_arbiter.sv | 88 ++++++++
 tb/tb_ram_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one RAM port between two masters
module ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_strb,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_strb,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [STRB_W-1:0] ram_strb,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              gnt_id,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              m0_ready_q, m0_ready_d;
    logic              m1_ready_q, m1_ready_d;
    logic              cand0, cand1, grant, win, acc;

    // arbitration in IDLE/DONE (served master excluded in DONE) and next-state logic
    always_comb begin
        acc        = state_q == ACCESS;
        cand0      = m0_req & (state_q == IDLE | (state_q == DONE & owner_q));
        cand1      = m1_req & (state_q == IDLE | (state_q == DONE & ~owner_q));
        grant      = cand0 | cand1;
        win        = (cand0 & cand1) ? ~last_q : cand1;
        state_d    = acc ? DONE : (grant ? ACCESS : IDLE);
        owner_d    = grant ? win : owner_q;
        last_d     = grant ? win : last_q;
        rdata_d    = acc ? ram_rdata : rdata_q;
        m0_ready_d = acc & ~owner_q;
        m1_ready_d = acc & owner_q;
    end

    // state registers; a reset cycle aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            rdata_q    <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            rdata_q    <= rdata_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
        end
    end

    // RAM port is driven only during ACCESS; writes are blocked in a reset cycle
    always_comb begin
        ram_we    = acc & (owner_q ? m1_we : m0_we) & reset;
        ram_addr  = acc ? (owner_q ? m1_addr : m0_addr) : '0;
        ram_wdata = acc ? (owner_q ? m1_wdata : m0_wdata) : '0;
        ram_strb  = acc ? (owner_q ? m1_strb : m0_strb) : '0;
        m0_rdata  = rdata_q;
        m1_rdata  = rdata_q;
        m0_ready  = m0_ready_q;
        m1_ready  = m1_ready_q;
        gnt_id    = owner_q;
        busy      = state_q != IDLE;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a small RAM model
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [2:0]  m0_strb = '0, m1_strb = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [2:0]  ram_strb;
    logic        gnt_id, busy;
    logic        preload = 1'b1;
    logic [31:0] mem [256];
    int          n_cmp = 0;
    int          n_err = 0;

    ram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_strb(m0_strb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_strb(m1_strb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_strb(ram_strb), .ram_rdata(ram_rdata), .gnt_id(gnt_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // word-addressed RAM with combinational read; word 8 (addr 0x20) preloaded
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;
        else if (preload) mem[8] <= 32'h1234_5678;
    end
    assign ram_rdata = mem[ram_addr[9:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_rdy0", m0_ready, 0);
        chk("rst_rdy1", m1_ready, 0);
        chk("rst_rdata", m0_rdata, 0);
        chk("rst_we", ram_we, 0);
        preload = 1'b0;
        reset = 1'b1;
        // m0 write DEADBEEF @0x10
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF; m0_strb = 3'b010;
        chk("w_idle_we", ram_we, 0);
        step();
        chk("w_acc_we", ram_we, 1);
        chk("w_acc_addr", ram_addr, 32'h10);
        chk("w_acc_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("w_acc_strb", ram_strb, 3'b010);
        chk("w_acc_busy", busy, 1);
        chk("w_acc_rdy", m0_ready, 0);
        step();
        chk("w_done_rdy", m0_ready, 1);
        chk("w_done_we", ram_we, 0);
        chk("w_done_addr", ram_addr, 0);
        m0_req = 0;
        step();
        chk("w_idle_busy", busy, 0);
        chk("w_idle_rdy", m0_ready, 0);
        // m0 read back
        m0_req = 1; m0_we = 0; m0_wdata = 0;
        step();
        chk("r_acc_we", ram_we, 0);
        step();
        chk("r_done_rdy0", m0_ready, 1);
        chk("r_done_rdy1", m1_ready, 0);
        chk("r_rdata0", m0_rdata, 32'hDEAD_BEEF);
        chk("r_rdata1", m1_rdata, 32'hDEAD_BEEF);
        m0_req = 0;
        step();
        // simultaneous requests right after reset: m0 then m1
        reset = 0; step(); reset = 1;
        m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        step();
        chk("tie_acc0_gnt", gnt_id, 0);
        chk("tie_acc0_addr", ram_addr, 32'h10);
        step();
        chk("tie_done0_rdy0", m0_ready, 1);
        chk("tie_done0_rdy1", m1_ready, 0);
        chk("tie_done0_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_req = 0;
        step();
        chk("tie_acc1_gnt", gnt_id, 1);
        chk("tie_acc1_addr", ram_addr, 32'h20);
        chk("tie_acc1_rdy0", m0_ready, 0);
        chk("tie_acc1_busy", busy, 1);
        step();
        chk("tie_done1_rdy1", m1_ready, 1);
        chk("tie_done1_rdata", m1_rdata, 32'h1234_5678);
        m1_req = 0;
        step();
        chk("tie_idle_busy", busy, 0);
        // both hold req for 6 transactions: strict alternation starting with m0
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_gnt", gnt_id, 32'(i % 2));
            chk("rr_acc_busy", busy, 1);
            step();
            chk("rr_rdy0", m0_ready, 32'(i % 2 == 0));
            chk("rr_rdy1", m1_ready, 32'(i % 2 == 1));
            chk("rr_rdata", m0_rdata, (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
            if (i == 5) begin m0_req = 0; m1_req = 0; end
        end
        step();
        chk("rr_end_busy", busy, 0);
        // m1 alone, 3 reads: one per 3 cycles
        m1_req = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("m1_acc_rdy", m1_ready, 0);
            chk("m1_acc_gnt", gnt_id, 1);
            step();
            chk("m1_done_rdy1", m1_ready, 1);
            chk("m1_done_rdy0", m0_ready, 0);
            if (i == 2) m1_req = 0;
            step();
            chk("m1_idle_rdy1", m1_ready, 0);
            chk("m1_idle_busy", busy, 0);
        end
        // reset during ACCESS of a write aborts it
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hCAFE_F00D;
        step();
        chk("ab_acc_we", ram_we, 1);
        reset = 0;
        #1;
        chk("ab_rst_we", ram_we, 0);
        m0_req = 0; m0_we = 0; m0_wdata = 0;
        step();
        chk("ab_busy", busy, 0);
        chk("ab_rdy", m0_ready, 0);
        chk("ab_rdata", m0_rdata, 0);
        reset = 1;
        m0_req = 1;
        step();
        step();
        chk("ab_read_rdy", m0_ready, 1);
        chk("ab_read_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_req = 0;
        step();
        // m0 pulses req mid-IDLE and withdraws before the edge
        m0_we = 1; m0_addr = 32'h44; m0_wdata = 32'h5555_AAAA; m0_strb = 3'b111;
        m0_req = 1;
        #2;
        m0_req = 0;
        step();
        chk("wd_busy", busy, 0);
        chk("wd_we", ram_we, 0);
        chk("wd_addr", ram_addr, 0);
        chk("wd_wdata", ram_wdata, 0);
        chk("wd_strb", ram_strb, 0);
        step();
        chk("wd_busy2", busy, 0);
        chk("wd_rdy", m0_ready, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
